fxp_alu_sequencer: RTL
======================

FXP_ALU_SEQUENCER -- requirements
Module: fxp_alu_sequencer

Interface
REQ-001 The module SHALL have parameters: Q, default 12, fractional bits; N, default 32, word width (sign-magnitude, bit N-1 = sign).
REQ-002 The module SHALL have ports, one per line:
- i_clk  in  1  clock; single clock domain, all logic on the rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_cmd_valid  in  1  command valid.
- o_cmd_ready  out  1  command accepted when valid and ready are both high.
- i_cmd_a, i_cmd_b  in  N  operands.
- i_cmd_op  in  2  operation: 00 add, 01 sub, 10 mul, 11 div.
- o_alu_a, o_alu_b  out  N  registered operands to the ALU.
- o_alu_op  out  2  registered op to the ALU.
- o_alu_start  out  1  divider start pulse.
- i_alu_out  in  N  ALU result.
- i_alu_done  in  1  divider idle/complete flag, high when idle.
- o_res_valid  out  1  result valid.
- i_res_ready  in  1  result consumed when valid and ready are both high.
- o_res  out  N  result.
- o_err_divz  out  1  divide-by-zero flag, qualified by o_res_valid.
- o_err_tmo  out  1  divider timeout flag; tied 0 without FXP_SEQ_TIMEOUT_EN.

Function
REQ-003 The FSM SHALL have the states IDLE, EXEC, DIV_START, DIV_WAIT and RESP, with IDLE the only state that accepts commands.
REQ-004 o_cmd_ready SHALL equal (state==IDLE) && i_alu_done, so no command is taken while a divide is still in flight, including one orphaned by reset.
REQ-005 On acceptance, the block SHALL register a, b and op into o_alu_a, o_alu_b and o_alu_op and hold them unchanged until RESP exits.
REQ-006 Transitions out of IDLE on acceptance SHALL be:
- op 00, 01 or 10: next state EXEC.
- op 11 with b[N-2:0]!=0: next state DIV_START.
- op 11 with b[N-2:0]==0: next state RESP, with the divide-by-zero result of REQ-010.
REQ-007 EXEC SHALL last exactly one cycle; at its closing edge i_alu_out is captured into o_res, and the FSM moves to RESP.
- o_res_valid therefore rises 2 cycles after the acceptance edge.
REQ-008 DIV_START SHALL last exactly one cycle with o_alu_start=1; o_alu_start SHALL be 0 in every other state.
REQ-009 DIV_WAIT SHALL capture i_alu_out into o_res on the first edge where i_alu_done==1, then move to RESP.
- Expected latency from acceptance to o_res_valid: N+Q+2 cycles (46 with the default parameters).
REQ-010 The divide-by-zero result SHALL be o_res = {a[N-1]^b[N-1], {N-1{1'b1}}} with o_err_divz=1; the ALU SHALL NOT be started for it.
REQ-011 RESP SHALL hold o_res_valid=1 with o_res and the error flags stable until i_res_ready=1, then return to IDLE on that edge.
REQ-012 A command SHALL NOT be accepted in the same cycle as a result handshake; the earliest next acceptance is the cycle after RESP exits.
REQ-013 The error flags SHALL be cleared when each new command is accepted.

Reset
REQ-014 On i_rst, the FSM SHALL enter IDLE and the following SHALL be set to 0: o_res_valid, o_alu_start, o_res, o_alu_a, o_alu_b, o_alu_op, o_err_divz and o_err_tmo.
REQ-015 Reset asserted mid-operation SHALL abandon the operation without producing a result.
- Any in-flight divide is then blocked from overlapping the next command by REQ-004.

Configuration
REQ-016 With FXP_SEQ_TIMEOUT_EN defined, a cycle counter SHALL run in DIV_WAIT, and after N+Q+4 cycles without i_alu_done the block SHALL:
- enter RESP with o_res=0 and o_err_tmo=1;
- then wait in IDLE for i_alu_done per REQ-004.
REQ-017 Without FXP_SEQ_TIMEOUT_EN, the counter SHALL be absent, DIV_WAIT SHALL wait indefinitely, and o_err_tmo SHALL be constant 0.

Verification
REQ-018 Add: a=0x00001800, b=0x00000800, op=00 -> o_res=0x00002000 with o_res_valid at acceptance+2 cycles and error flags 0.
REQ-019 Multiply: a=0x80001800 (-1.5), b=0x00000800, op=10 -> o_res equals the ALU model output for -0.75 with sign bit 1, and o_alu_start stays 0 throughout.
REQ-020 Divide: a=0x00001800, b=0x00000800, op=11 -> exactly one o_alu_start pulse, o_res=0x00003000 at acceptance+46 cycles, and o_cmd_ready low until RESP exits.
REQ-021 Divide by zero: b=0x80000000, a=0x00001000, op=11 -> o_res=0xFFFFFFFF and o_err_divz=1 at acceptance+1, with no start pulse.
REQ-022 Backpressure and reset:
- Hold i_res_ready=0 for 10 cycles -> o_res is stable and no new command is accepted.
- Pulse i_rst at DIV_WAIT+5 -> o_res_valid=0, and o_cmd_ready stays low until the model asserts i_alu_done.
REQ-023 Timeout (macro defined): model holds i_alu_done=0 -> o_err_tmo=1 and o_res=0 at DIV_START+N+Q+5.

Source files
------------

// File: rtl/fxp_alu_sequencer.sv
// fxp_alu_sequencer: command sequencer that feeds a fixed-point ALU and returns one result per command.
//   Q, N            : fractional bits and word width (sign-magnitude, bit N-1 is the sign)
//   i_clk, i_rst    : clock and synchronous active-high reset
//   i_cmd_*         : command handshake (valid/ready) with operands a, b and op (00 add, 01 sub, 10 mul, 11 div)
//   o_alu_*         : registered operands/op to the ALU and the divider start pulse
//   i_alu_out       : ALU result; i_alu_done is high while the divider is idle or complete
//   o_res_*         : result handshake (valid/ready), result word and error flags
// Optional feature: define FXP_SEQ_TIMEOUT_EN to add a divider timeout driving o_err_tmo.
module fxp_alu_sequencer #(
    parameter int Q = 12,
    parameter int N = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_cmd_valid,
    output logic         o_cmd_ready,
    input  logic [N-1:0] i_cmd_a,
    input  logic [N-1:0] i_cmd_b,
    input  logic [1:0]   i_cmd_op,
    output logic [N-1:0] o_alu_a,
    output logic [N-1:0] o_alu_b,
    output logic [1:0]   o_alu_op,
    output logic         o_alu_start,
    input  logic [N-1:0] i_alu_out,
    input  logic         i_alu_done,
    output logic         o_res_valid,
    input  logic         i_res_ready,
    output logic [N-1:0] o_res,
    output logic         o_err_divz,
    output logic         o_err_tmo
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_EXEC      = 3'd1;
    localparam logic [2:0] S_DIV_START = 3'd2;
    localparam logic [2:0] S_DIV_WAIT  = 3'd3;
    localparam logic [2:0] S_RESP      = 3'd4;
    logic [2:0] r_state;
    logic       w_acc;
    logic       w_bz;
    // Gating on i_alu_done keeps a divide orphaned by reset from overlapping the next command.
    assign o_cmd_ready = (r_state == S_IDLE) && i_alu_done;
    assign o_alu_start = r_state == S_DIV_START;
    assign o_res_valid = r_state == S_RESP;
    assign w_acc       = i_cmd_valid && o_cmd_ready;
    assign w_bz        = i_cmd_b[N-2:0] == '0;
`ifdef FXP_SEQ_TIMEOUT_EN
    localparam int             TW       = $clog2(N + Q + 4);
    localparam logic [TW-1:0]  TMO_LAST = TW'(N + Q + 3);
    logic [TW-1:0] r_tmo_cnt;
    logic          r_err_tmo;
    assign o_err_tmo = r_err_tmo;
`else
    assign o_err_tmo = 1'b0;
`endif
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            o_res      <= '0;
            o_alu_a    <= '0;
            o_alu_b    <= '0;
            o_alu_op   <= '0;
            o_err_divz <= 1'b0;
`ifdef FXP_SEQ_TIMEOUT_EN
            r_err_tmo  <= 1'b0;
            r_tmo_cnt  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (w_acc) begin
                    o_alu_a    <= i_cmd_a;
                    o_alu_b    <= i_cmd_b;
                    o_alu_op   <= i_cmd_op;
                    o_err_divz <= 1'b0;
`ifdef FXP_SEQ_TIMEOUT_EN
                    r_err_tmo  <= 1'b0;
`endif
                    if (i_cmd_op != 2'b11) r_state <= S_EXEC;
                    else if (!w_bz) r_state <= S_DIV_START;
                    else begin
                        // Divide by zero saturates to the largest magnitude; the divider is never started.
                        r_state    <= S_RESP;
                        o_res      <= {i_cmd_a[N-1] ^ i_cmd_b[N-1], {(N-1){1'b1}}};
                        o_err_divz <= 1'b1;
                    end
                end
                S_EXEC: begin
                    o_res   <= i_alu_out;
                    r_state <= S_RESP;
                end
                S_DIV_START: begin
                    r_state <= S_DIV_WAIT;
`ifdef FXP_SEQ_TIMEOUT_EN
                    r_tmo_cnt <= '0;
`endif
                end
                S_DIV_WAIT: if (i_alu_done) begin
                    o_res   <= i_alu_out;
                    r_state <= S_RESP;
                end
`ifdef FXP_SEQ_TIMEOUT_EN
                else if (r_tmo_cnt == TMO_LAST) begin
                    o_res     <= '0;
                    r_err_tmo <= 1'b1;
                    r_state   <= S_RESP;
                end else r_tmo_cnt <= r_tmo_cnt + 1'b1;
`endif
                S_RESP: if (i_res_ready) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
